// File: rtl/elevator_scheduler_if.sv
// ============================================================================
// Module      : elevator_scheduler_if
// Description : Call-button, tick and emergency inputs plus car status outputs
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface elevator_scheduler_if;
    logic       tick;
    logic [2:0] req;
    logic       emerg_in;
    logic [1:0] cur_floor;
    logic [1:0] next_floor;
    logic [2:0] pending;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       emerg_out;

    modport master (
        output tick, req, emerg_in,
        input  cur_floor, next_floor, pending, moving, dir_up, door_open, emerg_out
    );

    modport slave (
        input  tick, req, emerg_in,
        output cur_floor, next_floor, pending, moving, dir_up, door_open, emerg_out
    );
endinterface

`default_nettype wire

// File: rtl/elevator_scheduler.sv
// ============================================================================
// Module      : elevator_scheduler
// Description : Three-floor SCAN request scheduler with door dwell and e-stop
// Revision    : 1.0
// ============================================================================
`default_nettype none

module elevator_scheduler #(
    parameter int DOOR_TICKS = 3,
    parameter int MOVE_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_scheduler_if.slave  bus
);

    localparam int c_max_ticks = (DOOR_TICKS > MOVE_TICKS) ? DOOR_TICKS : MOVE_TICKS;
    localparam int c_tmr_w     = $clog2(c_max_ticks + 1);
    localparam logic [c_tmr_w-1:0] c_door_ld = c_tmr_w'(DOOR_TICKS);
    localparam logic [c_tmr_w-1:0] c_move_ld = c_tmr_w'(MOVE_TICKS);
    localparam logic [c_tmr_w-1:0] c_one     = c_tmr_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_DOOR  = 2'd2,
        S_EMERG = 2'd3
    } state_t;

    state_t               state_q;
    logic [1:0]           cur_q;
    logic [1:0]           next_q;
    logic [2:0]           pending_q;
    logic [c_tmr_w-1:0]   timer_q;
    logic                 dir_up_q;
    logic                 moving_q;
    logic                 door_q;
    logic                 emerg_q;

    logic [2:0] w_cur_oh;
    logic [2:0] w_nxt_oh;
    logic [2:0] w_req_set;
    logic [2:0] w_pend_set;
    logic       w_door_reload;
    logic       w_fwd;
    logic       w_rev;
    logic       w_nxt_fwd;

    function automatic logic req_above(input logic [2:0] p, input logic [1:0] f);
        case (f)
            2'd0:    req_above = p[1] | p[2];
            2'd1:    req_above = p[2];
            default: req_above = 1'b0;
        endcase
    endfunction

    function automatic logic req_below(input logic [2:0] p, input logic [1:0] f);
        case (f)
            2'd1:    req_below = p[0];
            2'd2:    req_below = p[0] | p[1];
            default: req_below = 1'b0;
        endcase
    endfunction

    always_comb begin
        w_cur_oh      = 3'b001 << cur_q;
        w_nxt_oh      = 3'b001 << next_q;
        // A call for the floor whose door is open only extends the dwell.
        w_door_reload = (state_q == S_DOOR) && |(bus.req & w_cur_oh);
        w_req_set     = (state_q == S_DOOR) ? (bus.req & ~w_cur_oh) : bus.req;
        w_pend_set    = pending_q | w_req_set;
        w_fwd         = dir_up_q ? req_above(pending_q, cur_q)  : req_below(pending_q, cur_q);
        w_rev         = dir_up_q ? req_below(pending_q, cur_q)  : req_above(pending_q, cur_q);
        w_nxt_fwd     = dir_up_q ? req_above(pending_q, next_q) : req_below(pending_q, next_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_q     <= 2'd0;
            next_q    <= 2'd0;
            pending_q <= 3'b000;
            timer_q   <= '0;
            dir_up_q  <= 1'b1;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
            emerg_q   <= 1'b0;
        end else if (bus.emerg_in) begin
            state_q   <= S_EMERG;
            next_q    <= cur_q;
            pending_q <= 3'b000;
            timer_q   <= '0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
            emerg_q   <= 1'b1;
        end else begin
            pending_q <= w_pend_set;
            case (state_q)
                S_IDLE: begin
                    if (|(pending_q & w_cur_oh)) begin
                        state_q   <= S_DOOR;
                        pending_q <= w_pend_set & ~w_cur_oh;
                        timer_q   <= c_door_ld;
                        door_q    <= 1'b1;
                    end else if (w_fwd) begin
                        state_q  <= S_MOVE;
                        next_q   <= dir_up_q ? cur_q + 2'd1 : cur_q - 2'd1;
                        timer_q  <= c_move_ld;
                        moving_q <= 1'b1;
                    end else if (w_rev) begin
                        state_q  <= S_MOVE;
                        dir_up_q <= ~dir_up_q;
                        next_q   <= dir_up_q ? cur_q - 2'd1 : cur_q + 2'd1;
                        timer_q  <= c_move_ld;
                        moving_q <= 1'b1;
                    end
                end
                S_MOVE: begin
                    if (bus.tick) begin
                        if (timer_q == c_one) begin
                            cur_q <= next_q;
                            // The end floors leave only one direction to scan.
                            if (next_q == 2'd0) begin
                                dir_up_q <= 1'b1;
                            end else if (next_q == 2'd2) begin
                                dir_up_q <= 1'b0;
                            end
                            if (|(pending_q & w_nxt_oh)) begin
                                state_q   <= S_DOOR;
                                pending_q <= w_pend_set & ~w_nxt_oh;
                                timer_q   <= c_door_ld;
                                moving_q  <= 1'b0;
                                door_q    <= 1'b1;
                            end else if (w_nxt_fwd) begin
                                next_q  <= dir_up_q ? next_q + 2'd1 : next_q - 2'd1;
                                timer_q <= c_move_ld;
                            end else begin
                                state_q  <= S_IDLE;
                                timer_q  <= '0;
                                moving_q <= 1'b0;
                            end
                        end else begin
                            timer_q <= timer_q - c_one;
                        end
                    end
                end
                S_DOOR: begin
                    if (w_door_reload) begin
                        timer_q <= c_door_ld;
                    end else if (bus.tick) begin
                        if (timer_q == c_one) begin
                            state_q <= S_IDLE;
                            timer_q <= '0;
                            door_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q - c_one;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    pending_q <= pending_q;
                    emerg_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cur_floor  = cur_q;
    assign bus.next_floor = next_q;
    assign bus.pending    = pending_q;
    assign bus.moving     = moving_q;
    assign bus.dir_up     = dir_up_q;
    assign bus.door_open  = door_q;
    assign bus.emerg_out  = emerg_q;

endmodule

`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Scoreboard bench: stimulus queues expected snapshots, monitor checks
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_elevator_scheduler;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;

    elevator_scheduler_if bus ();

    elevator_scheduler #(
        .DOOR_TICKS (3),
        .MOVE_TICKS (2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        int         cyc;
        logic [1:0] cur;
        logic [1:0] nxt;
        logic [2:0] pend;
        logic       mv;
        logic       dir;
        logic       door;
        logic       em;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every snapshot due in this cycle and compares all outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_chk = n_chk + 1;
            if (e.cyc != cyc || bus.cur_floor !== e.cur || bus.next_floor !== e.nxt ||
                bus.pending !== e.pend || bus.moving !== e.mv || bus.dir_up !== e.dir ||
                bus.door_open !== e.door || bus.emerg_out !== e.em) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got cur=%0d nxt=%0d pend=%b mv=%b dir=%b door=%b em=%b, want cur=%0d nxt=%0d pend=%b mv=%b dir=%b door=%b em=%b (cyc %0d/%0d)",
                         nm, bus.cur_floor, bus.next_floor, bus.pending, bus.moving, bus.dir_up,
                         bus.door_open, bus.emerg_out, e.cur, e.nxt, e.pend, e.mv, e.dir,
                         e.door, e.em, cyc, e.cyc);
            end
        end
    end

    task automatic step(input logic t, input logic [2:0] r, input logic e);
        bus.tick     = t;
        bus.req      = r;
        bus.emerg_in = e;
        @(posedge clk);
        #1;
        bus.tick     = 1'b0;
        bus.req      = 3'b000;
        bus.emerg_in = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 3'b000, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [1:0] cur, input logic [1:0] nxt,
                       input logic [2:0] pend, input logic mv, input logic dir,
                       input logic door, input logic em);
        exp_t e;
        n_chk = n_chk + 1;
        if (bus.cur_floor !== cur || bus.next_floor !== nxt || bus.pending !== pend ||
            bus.moving !== mv || bus.dir_up !== dir || bus.door_open !== door ||
            bus.emerg_out !== em) begin
            n_fail = n_fail + 1;
            $display("FAIL %s (direct): got cur=%0d nxt=%0d pend=%b mv=%b dir=%b door=%b em=%b, want cur=%0d nxt=%0d pend=%b mv=%b dir=%b door=%b em=%b",
                     nm, bus.cur_floor, bus.next_floor, bus.pending, bus.moving, bus.dir_up,
                     bus.door_open, bus.emerg_out, cur, nxt, pend, mv, dir, door, em);
        end
        e.cyc  = cyc;
        e.cur  = cur;
        e.nxt  = nxt;
        e.pend = pend;
        e.mv   = mv;
        e.dir  = dir;
        e.door = door;
        e.em   = em;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin
        cyc          = 0;
        n_chk        = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.req      = 3'b000;
        bus.emerg_in = 1'b0;

        // Ground floor call to floor 2, passing floor 1
        do_reset();
        chk("reset",      2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b100, 1'b0);
        chk("a_latch",    2'd0, 2'd0, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        chk("a_move",     2'd0, 2'd1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("a_tick1",    2'd0, 2'd1, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("a_floor1",   2'd1, 2'd2, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        ticks(2);
        chk("a_door2",    2'd2, 2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(2);
        chk("a_dwell",    2'd2, 2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        chk("a_idle2",    2'd2, 2'd2, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Pending 101 while passing floor 1 upward: serve 2, then 0
        do_reset();
        step(1'b0, 3'b100, 1'b0);
        step(1'b0, 3'b001, 1'b0);
        chk("b_move",     2'd0, 2'd1, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(2);
        chk("b_at1",      2'd1, 2'd2, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(2);
        chk("b_door2",    2'd2, 2'd2, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        chk("b_idle2",    2'd2, 2'd2, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        chk("b_down",     2'd2, 2'd1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        chk("b_at1d",     2'd1, 2'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        chk("b_door0",    2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        ticks(3);
        chk("b_idle0",    2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Door reload at floor 1 with one tick left
        step(1'b0, 3'b010, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        ticks(2);
        chk("c_door1",    2'd1, 2'd1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        ticks(2);
        step(1'b0, 3'b010, 1'b0);
        chk("c_reload",   2'd1, 2'd1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        ticks(2);
        chk("c_still",    2'd1, 2'd1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        ticks(1);
        chk("c_idle1",    2'd1, 2'd1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Emergency mid-move, requests ignored while stopped
        do_reset();
        step(1'b0, 3'b110, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        chk("d_move",     2'd0, 2'd1, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(1);
        step(1'b0, 3'b000, 1'b1);
        chk("d_emerg",    2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'b100, 1'b1);
        chk("d_hold",     2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'b100, 1'b0);
        chk("d_idle",     2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        chk("d_stay",     2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Emergency coinciding with the final move tick
        do_reset();
        step(1'b0, 3'b010, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        ticks(1);
        step(1'b1, 3'b000, 1'b1);
        chk("e_emerg",    2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0);
        chk("e_idle",     2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while door open at floor 2
        step(1'b0, 3'b100, 1'b0);
        step(1'b0, 3'b000, 1'b0);
        ticks(4);
        chk("f_door2",    2'd2, 2'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b1, 3'b011, 1'b0);
        reset = 1'b0;
        chk("f_reset",    2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            string nm;
            void'(exp_q.pop_front());
            nm = nm_q.pop_front();
            n_chk  = n_chk + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: got never-compared, want compared", nm);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler for the three-floor elevator: latches call-button pulses into a pending-request register, picks the next floor with a direction-preserving (SCAN) policy, and sequences the car through idle, travel, door-dwell and emergency states. It sits between the button debouncers and the floor display/motor path. `cur_floor`/`next_floor` feed the seven-segment multiplexer, the next-floor LED logic and the motor driver. All timing advances on a one-cycle `tick` enable from the clock divider, so the block runs on the fast board clock.

## Interface
- `DOOR_TICKS`, default 3: ticks the door stays open per stop (≥1).
- `MOVE_TICKS`, default 2: ticks to travel one floor (≥1).
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: one-`clk`-wide enable pulse (1 Hz); all timers count only on cycles with `tick`=1.
- `req` in 3: call-button pulses; bit0 ground, bit1 first, bit2 second; any width ≥1 cycle.
- `emerg_in` in 1: emergency stop level.
- `cur_floor` out 2: floor the car is at, 0..2; 3 never driven.
- `next_floor` out 2: travel target in MOVE; equals `cur_floor` otherwise.
- `pending` out 3: latched outstanding requests.
- `moving` out 1: high in MOVE.
- `dir_up` out 1: current scan direction, 1 = up.
- `door_open` out 1: high in DOOR.
- `emerg_out` out 1: high in EMERG.

## Operation
- States: IDLE, MOVE, DOOR, EMERG. Timer width is ceil(log2(max(DOOR_TICKS,MOVE_TICKS)+1)).
- Latching: `pending[i]` sets on any cycle with `req[i]`=1. It clears only when DOOR is entered at floor i. Clear wins over set in the same cycle.
- IDLE evaluates the registered `pending` every clk:
  - `pending[cur]` → DOOR: clear that bit, timer=DOOR_TICKS.
  - Else a request beyond cur in `dir_up` → MOVE toward it one floor, timer=MOVE_TICKS.
  - Else a request in the opposite direction → flip `dir_up`, then MOVE.
  - Else stay in IDLE.
- MOVE: each tick decrements the timer. On the tick where timer=1:
  - `cur_floor`←`next_floor`.
  - If `pending[new cur]` → DOOR (clear bit, timer=DOOR_TICKS).
  - Else if a request lies further in `dir_up` → stay in MOVE with `next_floor` one further and timer=MOVE_TICKS.
  - Else → IDLE.
- DOOR: each tick decrements; on timer=1 → IDLE. A `req` for `cur_floor` while in DOOR reloads the timer to DOOR_TICKS and does not set `pending`.
- Direction at floor 0 forces `dir_up`=1; at floor 2 forces `dir_up`=0.
- EMERG: `emerg_in`=1 in any state → EMERG next cycle, overriding tick and request events that same cycle.
  - Clears `pending` and the timer.
  - Holds `cur_floor` (an aborted move stays at the departure floor).
  - Sets `next_floor`=`cur_floor` and ignores `req`.
  - Leaves EMERG to IDLE on the first cycle with `emerg_in`=0.
- Reset values: state IDLE, `cur_floor`=0, `next_floor`=0, `pending`=0, `dir_up`=1, `moving`=0, `door_open`=0, `emerg_out`=0, timer 0. Reset mid-move abandons the move.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Latency from a `req` pulse to the `pending` bit: 1 cycle. From `pending` visible in IDLE to MOVE/DOOR: 1 cycle, so req at cycle N gives `moving`=1 at N+2.
- Travel of one floor: exactly MOVE_TICKS ticks; `cur_floor` updates in the cycle after the MOVE_TICKS-th tick.
- Door dwell: DOOR_TICKS ticks, then IDLE, and the next decision follows 1 cycle after that.
- `emerg_in` rising to `emerg_out`=1: 1 cycle. Falling to IDLE: 1 cycle.
- `tick` asserted on consecutive cycles is legal; each cycle counts as one tick.

## Test plan
- Reset, then `req`=3'b100 at floor 0 with defaults:
  - `pending`=100 next cycle.
  - MOVE with `next_floor`=1, `cur_floor`=1 after 2 ticks, `next_floor`=2, `cur_floor`=2 after 2 more ticks.
  - DOOR for 3 ticks, `pending`=000, then IDLE.
- Car at floor 1 moving up with `pending`=101:
  - Serves 2 first.
  - Flips `dir_up`=0, then serves 0.
  - Ends at floor 0 in IDLE with `dir_up`=1.
- In DOOR at floor 1, pulse `req`=3'b010 with 1 tick left:
  - Timer reloads to 3; door stays open 3 more ticks.
  - `pending` stays 000.
- Mid-MOVE from 0 toward 1 with `pending`=110, assert `emerg_in`:
  - Next cycle `emerg_out`=1, `moving`=0, `pending`=000, `cur_floor`=0.
  - Drop `emerg_in` → IDLE 1 cycle later.
- Same cycle `emerg_in`=1, `tick`=1 and the last MOVE tick: EMERG wins, `cur_floor` does not advance.
- Assert `reset` during DOOR at floor 2: all outputs return to reset values the next cycle.
